// File: rtl/beam_threshold_ctrl_if.sv
// Bundle of the threshold staging port, update control and beam load bus
// shared between the threshold controller and whatever drives it.
interface beam_threshold_ctrl_if #(
  parameter int THRESH_BITS = 18
);
  logic [THRESH_BITS-1:0] thresh_dat_i;
  logic [7:0]             thresh_idx_i;
  logic                   thresh_valid_i;
  logic                   thresh_ready_o;
  logic                   update_req_i;
  logic                   busy_o;
  logic [7:0]             beam_addr_o;
  logic [THRESH_BITS-1:0] beam_dat_o;
  logic                   beam_we_o;
  logic                   beam_commit_o;
  logic                   err_o;
  logic                   err_clr_i;

  // Host side: stages thresholds, requests updates, observes the beam bus.
  modport master (
    output thresh_dat_i,
    output thresh_idx_i,
    output thresh_valid_i,
    input  thresh_ready_o,
    output update_req_i,
    input  busy_o,
    input  beam_addr_o,
    input  beam_dat_o,
    input  beam_we_o,
    input  beam_commit_o,
    input  err_o,
    output err_clr_i
  );

  // Controller side.
  modport slave (
    input  thresh_dat_i,
    input  thresh_idx_i,
    input  thresh_valid_i,
    output thresh_ready_o,
    input  update_req_i,
    output busy_o,
    output beam_addr_o,
    output beam_dat_o,
    output beam_we_o,
    output beam_commit_o,
    output err_o,
    input  err_clr_i
  );
endinterface

// File: rtl/beam_threshold_ctrl.sv
// Beam threshold controller.
// Thresholds are staged per beam while idle, then on an update request they
// are streamed one beam per cycle into the beam comparator shadow registers,
// followed by a single commit pulse and a quiet holdoff period. Update
// requests arriving while busy are merged into one pending update.
module beam_threshold_ctrl #(
  parameter int                     NBEAMS         = 2,
  parameter int                     THRESH_BITS    = 18,
  parameter logic [THRESH_BITS-1:0] THRESH_DEFAULT = THRESH_BITS'(18'h3FFFF),
  parameter int                     HOLDOFF        = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  beam_threshold_ctrl_if.slave ctrl_if
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [7:0] LAST_ADDR  = 8'(NBEAMS - 1);
  localparam logic [8:0] NBEAMS_W   = 9'(NBEAMS);
  localparam logic [3:0] HOLD_INIT  = 4'(HOLDOFF - 1);

  logic [1:0]             r_state;
  logic [7:0]             r_cnt;
  logic [3:0]             r_hold;
  logic                   r_pending;
  logic                   r_err;
  logic [THRESH_BITS-1:0] r_stage [NBEAMS];

  logic                   w_idle;
  logic                   w_accept;
  logic                   w_idx_ok;
  logic                   w_bad_wr;
  logic                   w_start;
  logic                   w_we;
  logic [THRESH_BITS-1:0] w_rd_dat;

  // Writes are only taken while idle; an index past the last beam is
  // swallowed and flagged rather than stalled, so the host never hangs.
  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && ctrl_if.thresh_valid_i;
  assign w_idx_ok = ({1'b0, ctrl_if.thresh_idx_i} < NBEAMS_W);
  assign w_bad_wr = w_accept && !w_idx_ok;
  assign w_start  = w_idle && (ctrl_if.update_req_i || r_pending);
  assign w_we     = (r_state == ST_LOAD);

  // Sequencer: IDLE -> LOAD (one beam per cycle) -> COMMIT -> HOLD -> IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_start) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (r_cnt == LAST_ADDR) begin
            r_state <= ST_COMMIT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_COMMIT: begin
          r_state <= ST_HOLD;
          r_hold  <= HOLD_INIT;
        end
        ST_HOLD: begin
          if (r_hold == 4'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_hold <= r_hold - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Remember an update request seen while busy; several collapse into one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending <= 1'b0;
    end else if (w_start) begin
      r_pending <= 1'b0;
    end else if (ctrl_if.update_req_i) begin
      r_pending <= 1'b1;
    end
  end

  // Sticky bad-index flag; a fresh error in the clearing cycle keeps it set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_bad_wr) begin
      r_err <= 1'b1;
    end else if (ctrl_if.err_clr_i) begin
      r_err <= 1'b0;
    end
  end

  // Staging registers; a write in the cycle that launches an update lands
  // before the first beam is read out, so it is included in that update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NBEAMS; i++) begin
        r_stage[i] <= THRESH_DEFAULT;
      end
    end else if (w_accept && w_idx_ok) begin
      for (int i = 0; i < NBEAMS; i++) begin
        if (ctrl_if.thresh_idx_i == 8'(i)) begin
          r_stage[i] <= ctrl_if.thresh_dat_i;
        end
      end
    end
  end

  // Select the staging word for the beam currently being loaded.
  always_comb begin
    w_rd_dat = '0;
    for (int i = 0; i < NBEAMS; i++) begin
      if (r_cnt == 8'(i)) begin
        w_rd_dat = r_stage[i];
      end
    end
  end

  // Outputs decode straight from state so reset silences them at once.
  assign ctrl_if.thresh_ready_o = w_idle;
  assign ctrl_if.busy_o         = !w_idle;
  assign ctrl_if.beam_we_o      = w_we;
  assign ctrl_if.beam_commit_o  = (r_state == ST_COMMIT);
  assign ctrl_if.beam_addr_o    = w_we ? r_cnt : 8'd0;
  assign ctrl_if.beam_dat_o     = w_we ? w_rd_dat : '0;
  assign ctrl_if.err_o          = r_err;

endmodule

// File: doc/beam_threshold_ctrl.md
BEAM_THRESHOLD_CTRL -- requirements
Module: beam_threshold_ctrl

Interface
REQ-001 SHALL have parameter NBEAMS, default 2, number of beams served (1..255).
REQ-002 SHALL have parameter THRESH_BITS, default 18, threshold word width.
REQ-003 SHALL have parameter THRESH_DEFAULT, default 18'h3FFFF, reset threshold value.
REQ-004 SHALL have parameter HOLDOFF, default 4, post-commit quiet cycles (1..15).
REQ-005 SHALL have port clk_i  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port thresh_dat_i  in  THRESH_BITS  threshold value to stage.
REQ-008 SHALL have port thresh_idx_i  in  8  target beam index.
REQ-009 SHALL have port thresh_valid_i  in  1  staging write request.
REQ-010 SHALL have port thresh_ready_o  out  1  staging write accepted when valid and ready both high.
REQ-011 SHALL have port update_req_i  in  1  single-cycle request to push staged thresholds to beams.
REQ-012 SHALL have port busy_o  out  1  high in any state other than IDLE.
REQ-013 SHALL have port beam_addr_o  out  8  beam index being loaded.
REQ-014 SHALL have port beam_dat_o  out  THRESH_BITS  threshold being loaded.
REQ-015 SHALL have port beam_we_o  out  1  load strobe to beam comparator shadow registers.
REQ-016 SHALL have port beam_commit_o  out  1  single-cycle pulse: all beams switch to loaded thresholds.
REQ-017 SHALL have port err_o  out  1  sticky out-of-range index flag.
REQ-018 SHALL have port err_clr_i  in  1  clears err_o.

Function
REQ-019 SHALL hold NBEAMS staging registers of THRESH_BITS each.
REQ-020 SHALL implement states IDLE, LOAD, COMMIT, HOLD.
REQ-021 SHALL drive thresh_ready_o high only in IDLE.
REQ-022 SHALL write thresh_dat_i into staging[thresh_idx_i] on an accepted write with thresh_idx_i < NBEAMS.
REQ-023 SHALL accept but discard a write with thresh_idx_i >= NBEAMS, and set err_o the following cycle.
REQ-024 SHALL clear err_o on err_clr_i; a simultaneous new error SHALL win (err_o stays 1).
REQ-025 SHALL latch update_req_i in any state into a pending flag; a further request while pending SHALL merge (one update).
REQ-026 SHALL transition IDLE->LOAD when update_req_i or pending is set, clearing pending.
REQ-027 SHALL include a write accepted in the same cycle as the IDLE->LOAD decision in the loaded data.
REQ-028 SHALL in LOAD assert beam_we_o for exactly NBEAMS consecutive cycles, beam_addr_o 0..NBEAMS-1 ascending, beam_dat_o = staging[beam_addr_o].
REQ-029 SHALL go LOAD->COMMIT after address NBEAMS-1, asserting beam_commit_o for exactly one cycle.
REQ-030 SHALL go COMMIT->HOLD, remain HOLDOFF cycles, then return to IDLE.
REQ-031 SHALL, for update_req_i at cycle 0 in IDLE, give beam_we_o on cycles 1..NBEAMS, beam_commit_o on cycle NBEAMS+1, busy_o high cycles 1..NBEAMS+1+HOLDOFF.
REQ-032 SHALL execute a request pending at HOLD exit by going HOLD->IDLE->LOAD (one IDLE cycle, writes accepted there).
REQ-033 SHALL drive beam_addr_o and beam_dat_o to 0 when beam_we_o is low.

Reset
REQ-034 SHALL on rst_i asynchronously force state IDLE, pending 0, err_o 0, beam_we_o 0, beam_commit_o 0, beam_addr_o 0, beam_dat_o 0, busy_o 0, every staging register THRESH_DEFAULT.
REQ-035 SHALL, on reset during LOAD or COMMIT, emit no further beam_we_o or beam_commit_o; thresh_ready_o SHALL be 1 from the first cycle after rst_i deasserts.

Verification
REQ-036 SHALL cover: reset, then update_req_i -> beam_we_o 2 cycles, addrs 0,1, data 0x3FFFF both; commit on cycle 3; busy_o low after cycle 7.
REQ-037 SHALL cover: write idx0=0x100, idx1=0x200, update -> beam_dat_o 0x100 then 0x200, commit one cycle after.
REQ-038 SHALL cover: write idx1=0x055 in same cycle as update_req_i -> addr1 carries 0x055.
REQ-039 SHALL cover: write idx=5 -> no staging change, err_o=1 next cycle; err_clr_i -> err_o=0.
REQ-040 SHALL cover: three update_req_i pulses during LOAD/HOLD -> exactly two commit pulses total, second sequence after one IDLE cycle.
REQ-041 SHALL cover: rst_i asserted mid-LOAD -> beam_we_o drops immediately, no commit, staging reads back 0x3FFFF on next update.
